apb_latency_scaler: RTL and testbench

- Parametrised APB latency scaler between the APB master and one slow APB device.
- Makes the core see the device latency multiplied by a fixed-point ratio, so memory timing at the core-to-device clock ratio can be emulated. The ratio is set at run time.
- The fractional remainder carries from one transaction to the next, so the average latency has no long-run drift.
- Generalised in address width, data width, accumulator width and fixed-point precision.

---
 rtl/apb_latency_scaler.sv | 204 ++++++++++++++++++++
 tb/tb_apb_latency_scaler.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_latency_scaler.sv
// APB latency scaler: stretches the latency of one downstream APB device by a run-time fixed-point ratio.
// Define APB_LATENCY_SCALER_STATS_EN to add saturating transaction and stall counters.
module apb_latency_scaler #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int FRAC_BITS = 4,
    parameter int ACC_W     = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [15:0]         cfg_ratio,
    input  logic [ADDR_W-1:0]   in_paddr,
    input  logic                in_psel,
    input  logic                in_penable,
    input  logic [2:0]          in_pprot,
    input  logic                in_pwrite,
    input  logic [DATA_W-1:0]   in_pwdata,
    input  logic [DATA_W/8-1:0] in_pstrb,
    output logic                in_pready,
    output logic [DATA_W-1:0]   in_prdata,
    output logic                in_pslverr,
    output logic [ADDR_W-1:0]   out_paddr,
    output logic                out_psel,
    output logic                out_penable,
    output logic [2:0]          out_pprot,
    output logic                out_pwrite,
    output logic [DATA_W-1:0]   out_pwdata,
    output logic [DATA_W/8-1:0] out_pstrb,
    input  logic                out_pready,
    input  logic [DATA_W-1:0]   out_prdata,
    input  logic                out_pslverr
`ifdef APB_LATENCY_SCALER_STATS_EN
    ,
    output logic [31:0]         stat_txn_cnt,
    output logic [31:0]         stat_stall_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_TRANS = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    localparam logic [ACC_W-1:0] ACC_ZERO = {ACC_W{1'b0}};
    localparam logic [ACC_W-1:0] ACC_ONE  = {{(ACC_W-1){1'b0}}, 1'b1};

    state_t               r_state;
    logic [15:0]          r_ratio_q;
    logic [ACC_W-1:0]     r_acc;
    logic [ACC_W-1:0]     r_ncyc;
    logic [ACC_W-1:0]     r_cnt;
    logic [FRAC_BITS-1:0] r_frac_carry;
    logic [DATA_W-1:0]    r_cap_prdata;
    logic                 r_cap_pslverr;
    logic                 r_in_pready;
    logic [DATA_W-1:0]    r_in_prdata;
    logic                 r_in_pslverr;

    logic [ACC_W-1:0]     w_acc_start;
    logic [ACC_W-1:0]     w_acc_next;
    logic [ACC_W-1:0]     w_ncyc_next;
    logic [ACC_W-1:0]     w_acc_int;
    logic [ACC_W:0]       w_ncyc_p1;
    logic [ACC_W-1:0]     w_wait;

    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                                 input logic [ACC_W-1:0] b);
        logic [ACC_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum[ACC_W]) begin
            return {ACC_W{1'b1}};
        end
        return sum[ACC_W-1:0];
    endfunction

    // Accumulator arithmetic and the extra wait count owed once the device has answered
    always_comb begin
        w_acc_start = sat_add(ACC_W'(r_frac_carry), ACC_W'(cfg_ratio));
        w_acc_next  = sat_add(r_acc, ACC_W'(r_ratio_q));
        w_ncyc_next = sat_add(r_ncyc, ACC_ONE);
        w_acc_int   = w_acc_next >> FRAC_BITS;
        w_ncyc_p1   = {1'b0, w_ncyc_next} + {{ACC_W{1'b0}}, 1'b1};
        w_wait      = ACC_ZERO;
        if ({1'b0, w_acc_int} > w_ncyc_p1) begin
            w_wait = w_acc_int - w_ncyc_next - ACC_ONE;
        end else begin
            w_wait = ACC_ZERO;
        end
    end

    // Downstream request: transparent except while the scaled wait is running
    always_comb begin
        out_pprot = in_pprot;
        if (r_state == S_WAIT) begin
            out_psel    = 1'b0;
            out_penable = 1'b0;
            out_pwrite  = 1'b0;
            out_paddr   = {ADDR_W{1'b0}};
            out_pwdata  = {DATA_W{1'b0}};
            out_pstrb   = {(DATA_W/8){1'b0}};
        end else begin
            out_psel    = in_psel;
            out_penable = in_penable;
            out_pwrite  = in_pwrite;
            out_paddr   = in_paddr;
            out_pwdata  = in_pwdata;
            out_pstrb   = in_pstrb;
        end
    end

    // Transaction FSM; the response is registered one cycle ahead so it lands when the count hits 0
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_ratio_q     <= 16'h0000;
            r_acc         <= ACC_ZERO;
            r_ncyc        <= ACC_ZERO;
            r_cnt         <= ACC_ZERO;
            r_frac_carry  <= {FRAC_BITS{1'b0}};
            r_cap_prdata  <= {DATA_W{1'b0}};
            r_cap_pslverr <= 1'b0;
            r_in_pready   <= 1'b0;
            r_in_prdata   <= {DATA_W{1'b0}};
            r_in_pslverr  <= 1'b0;
        end else begin
            r_in_pready  <= 1'b0;
            r_in_prdata  <= {DATA_W{1'b0}};
            r_in_pslverr <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in_psel) begin
                        r_ratio_q <= cfg_ratio;
                        r_acc     <= w_acc_start;
                        r_ncyc    <= ACC_ONE;
                        r_state   <= S_TRANS;
                    end
                end
                S_TRANS: begin
                    r_acc  <= w_acc_next;
                    r_ncyc <= w_ncyc_next;
                    if (out_pready) begin
                        r_cap_prdata  <= out_prdata;
                        r_cap_pslverr <= out_pslverr;
                        r_frac_carry  <= w_acc_next[FRAC_BITS-1:0];
                        r_cnt         <= w_wait;
                        r_state       <= S_WAIT;
                        if (w_wait == ACC_ZERO) begin
                            r_in_pready  <= 1'b1;
                            r_in_prdata  <= out_prdata;
                            r_in_pslverr <= out_pslverr;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt != ACC_ZERO) begin
                        r_cnt <= r_cnt - ACC_ONE;
                    end
                    if (r_cnt == ACC_ONE) begin
                        r_in_pready  <= 1'b1;
                        r_in_prdata  <= r_cap_prdata;
                        r_in_pslverr <= r_cap_pslverr;
                    end
                    // A zero count means in_pready is high this cycle
                    if (r_cnt == ACC_ZERO) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_pready  = r_in_pready;
    assign in_prdata  = r_in_prdata;
    assign in_pslverr = r_in_pslverr;

`ifdef APB_LATENCY_SCALER_STATS_EN
    logic [31:0] r_stat_txn;
    logic [31:0] r_stat_stall;

    // Saturating counters of completed transactions and stalled WAIT cycles
    always_ff @(posedge clock) begin
        if (reset) begin
            r_stat_txn   <= 32'd0;
            r_stat_stall <= 32'd0;
        end else if (r_state == S_WAIT) begin
            if (r_in_pready) begin
                if (r_stat_txn != 32'hFFFF_FFFF) begin
                    r_stat_txn <= r_stat_txn + 32'd1;
                end
            end else if (r_stat_stall != 32'hFFFF_FFFF) begin
                r_stat_stall <= r_stat_stall + 32'd1;
            end
        end
    end

    assign stat_txn_cnt   = r_stat_txn;
    assign stat_stall_cnt = r_stat_stall;
`endif

endmodule

// File: tb/tb_apb_latency_scaler.sv
// Scoreboard bench for apb_latency_scaler: a reference latency model feeds a queue that is
// drained when in_pready is observed. Define APB_LATENCY_SCALER_STATS_EN to cover the counters.
module tb_apb_latency_scaler;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic                clock = 1'b0;
    logic                reset;
    logic [15:0]         cfg_ratio;
    logic [ADDR_W-1:0]   in_paddr;
    logic                in_psel;
    logic                in_penable;
    logic [2:0]          in_pprot;
    logic                in_pwrite;
    logic [DATA_W-1:0]   in_pwdata;
    logic [DATA_W/8-1:0] in_pstrb;
    logic                in_pready;
    logic [DATA_W-1:0]   in_prdata;
    logic                in_pslverr;
    logic [ADDR_W-1:0]   out_paddr;
    logic                out_psel;
    logic                out_penable;
    logic [2:0]          out_pprot;
    logic                out_pwrite;
    logic [DATA_W-1:0]   out_pwdata;
    logic [DATA_W/8-1:0] out_pstrb;
    logic                out_pready;
    logic [DATA_W-1:0]   out_prdata;
    logic                out_pslverr;
`ifdef APB_LATENCY_SCALER_STATS_EN
    logic [31:0]         stat_txn_cnt;
    logic [31:0]         stat_stall_cnt;
`endif

    typedef struct {
        int          lat;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          m_carry  = 0;
    int          dev_n    = 2;
    int          dev_cnt  = 0;
    logic [31:0] dev_data = 32'h0;
    logic        dev_err  = 1'b0;
    logic        dev_stray = 1'b0;

    apb_latency_scaler dut (
        .clock          (clock),
        .reset          (reset),
        .cfg_ratio      (cfg_ratio),
        .in_paddr       (in_paddr),
        .in_psel        (in_psel),
        .in_penable     (in_penable),
        .in_pprot       (in_pprot),
        .in_pwrite      (in_pwrite),
        .in_pwdata      (in_pwdata),
        .in_pstrb       (in_pstrb),
        .in_pready      (in_pready),
        .in_prdata      (in_prdata),
        .in_pslverr     (in_pslverr),
        .out_paddr      (out_paddr),
        .out_psel       (out_psel),
        .out_penable    (out_penable),
        .out_pprot      (out_pprot),
        .out_pwrite     (out_pwrite),
        .out_pwdata     (out_pwdata),
        .out_pstrb      (out_pstrb),
        .out_pready     (out_pready),
        .out_prdata     (out_prdata),
        .out_pslverr    (out_pslverr)
`ifdef APB_LATENCY_SCALER_STATS_EN
        ,
        .stat_txn_cnt   (stat_txn_cnt),
        .stat_stall_cnt (stat_stall_cnt)
`endif
    );

    always #5 clock = ~clock;

    // Device: ready on downstream cycle dev_n (setup counted as 1); junk data when not ready
    always @(posedge clock) begin
        if (out_psel && !out_pready) dev_cnt <= dev_cnt + 1;
        else                         dev_cnt <= 0;
    end
    assign out_pready  = dev_stray | (out_psel && out_penable && (dev_cnt == dev_n - 1));
    assign out_prdata  = out_pready ? dev_data : ~dev_data;
    assign out_pslverr = out_pready ? dev_err : ~dev_err;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_cycles(input int k);
        for (int i = 0; i < k; i++) begin
            next_cycle();
            in_psel    = 1'b0;
            in_penable = 1'b0;
            #1;
            check_val("idle_nopready", 64'(in_pready), 64'd0);
        end
    endtask

    // Drives one APB transfer starting in the current cycle; returns after the in_pready cycle
    task automatic run_txn(input logic [15:0] ratio, input int n, input logic [31:0] data,
                           input logic err, input logic wr);
        exp_t e;
        exp_t got;
        int   acc;
        int   ai;
        bit   done;
        acc    = m_carry + int'(ratio) * n;
        ai     = acc >> 4;
        e.lat  = (ai > n + 1) ? ai : n + 1;
        e.data = data;
        e.err  = err;
        m_carry = acc % 16;
        sb_q.push_back(e);

        dev_n      = n;
        dev_data   = data;
        dev_err    = err;
        in_psel    = 1'b1;
        in_penable = 1'b0;
        in_pwrite  = wr;
        in_paddr   = $urandom;
        in_pwdata  = $urandom;
        in_pstrb   = 4'($urandom_range(1, 15));
        in_pprot   = 3'($urandom_range(0, 7));
        cfg_ratio  = ratio;
        #1;
        check_val("setup_psel", 64'(out_psel), 64'd1);
        check_val("setup_addr", 64'(out_paddr), 64'(in_paddr));
        check_val("setup_wdata", 64'({out_pwrite, out_pstrb, out_pwdata}),
                  64'({in_pwrite, in_pstrb, in_pwdata}));
        check_val("setup_nopready", 64'(in_pready), 64'd0);
        done = 1'b0;
        for (int c = 1; c < 400 && !done; c++) begin
            next_cycle();
            in_penable = 1'b1;
            cfg_ratio  = 16'hFFFF;
            #1;
            check_val("pprot_copy", 64'(out_pprot), 64'(in_pprot));
            if (c >= n) begin
                check_val("wait_ctl_zero", 64'({out_psel, out_penable, out_pwrite, out_pstrb}), 64'd0);
                check_val("wait_addr_zero", {out_paddr, out_pwdata}, 64'd0);
            end else begin
                check_val("access_penable", 64'(out_penable), 64'd1);
            end
            if (in_pready) begin
                done = 1'b1;
                check_val("sb_depth", 64'(sb_q.size()), 64'd1);
                if (sb_q.size() > 0) begin
                    got = sb_q.pop_front();
                    check_val("latency", 64'(c + 1), 64'(got.lat));
                    check_val("prdata", 64'(in_prdata), 64'(got.data));
                    check_val("pslverr", 64'(in_pslverr), 64'(got.err));
                end
            end else begin
                check_val("resp_zero", 64'({in_pslverr, in_prdata}), 64'd0);
            end
        end
        check_val("txn_done", 64'(done), 64'd1);
    endtask

    initial begin
        reset      = 1'b1;
        cfg_ratio  = 16'h0000;
        in_paddr   = 32'h0;
        in_psel    = 1'b1;
        in_penable = 1'b0;
        in_pprot   = 3'd5;
        in_pwrite  = 1'b0;
        in_pwdata  = 32'h0;
        in_pstrb   = 4'h0;
        repeat (3) next_cycle();
        #1;
        check_val("rst_pready", 64'(in_pready), 64'd0);
        check_val("rst_prdata", 64'(in_prdata), 64'd0);
        check_val("rst_pslverr", 64'(in_pslverr), 64'd0);
        check_val("rst_psel_pass", 64'(out_psel), 64'd1);
        next_cycle();
        reset   = 1'b0;
        in_psel = 1'b0;
        #1;
        check_val("idle_psel_pass", 64'(out_psel), 64'd0);

        // Stray device ready while idle must be ignored
        dev_stray = 1'b1;
        idle_cycles(2);
        dev_stray = 1'b0;
        idle_cycles(1);

        // Ratio 5.0, n=2: latency 10, run twice
        next_cycle();
        run_txn(16'h0050, 2, 32'h1234_5678, 1'b0, 1'b0);
        idle_cycles(1);
        next_cycle();
        run_txn(16'h0050, 2, 32'hCAFE_0001, 1'b0, 1'b1);
        idle_cycles(1);
`ifdef APB_LATENCY_SCALER_STATS_EN
        check_val("stat_txn", 64'(stat_txn_cnt), 64'd2);
        check_val("stat_stall", 64'(stat_stall_cnt), 64'd14);
`endif

        // Ratio 2.5, n=3, back to back: latencies 7, 8, 7
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            run_txn(16'h0028, 3, 32'hA000_0000 + 32'(i), 1'b0, 1'(i));
        end
        idle_cycles(2);

        // Sub-unity ratio gives the minimum latency n+1
        next_cycle();
        run_txn(16'h0008, 4, 32'h5555_AAAA, 1'b0, 1'b0);
        idle_cycles(1);

        // Slave error with distinctive data
        next_cycle();
        run_txn(16'h0030, 2, 32'hDEAD_BEEF, 1'b1, 1'b0);
        idle_cycles(1);

        // Zero ratio
        next_cycle();
        run_txn(16'h0000, 2, 32'h0BAD_F00D, 1'b0, 1'b1);
        idle_cycles(1);
        next_cycle();
        run_txn(16'h0028, 3, 32'h1111_2222, 1'b0, 1'b0);
        idle_cycles(1);

        // Reset in the third WAIT cycle of a 2.5 transfer: no response, carry cleared
        next_cycle();
        dev_n      = 3;
        dev_data   = 32'h7777_8888;
        dev_err    = 1'b0;
        in_psel    = 1'b1;
        in_penable = 1'b0;
        in_pwrite  = 1'b0;
        cfg_ratio  = 16'h0028;
        #1;
        for (int c = 1; c <= 5; c++) begin
            next_cycle();
            in_penable = 1'b1;
            if (c == 5) reset = 1'b1;
            #1;
            check_val("abort_nopready", 64'(in_pready), 64'd0);
        end
        check_val("abort_wait_psel", 64'(out_psel), 64'd0);
        next_cycle();
        reset   = 1'b0;
        m_carry = 0;
        #1;
`ifdef APB_LATENCY_SCALER_STATS_EN
        check_val("rst_stat_txn", 64'(stat_txn_cnt), 64'd0);
        check_val("rst_stat_stall", 64'(stat_stall_cnt), 64'd0);
`endif
        run_txn(16'h0028, 3, 32'h3333_4444, 1'b0, 1'b0);
        idle_cycles(1);

        // Large ratio
        next_cycle();
        run_txn(16'h00FF, 5, 32'hF0F0_0F0F, 1'b1, 1'b1);
        idle_cycles(2);

        check_val("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
